// File: rtl/blit_pkg.sv
// Shared definitions for the blitter source path.
//   - ST_* : sequencer state encoding (2 bits)
//   - PHRASE_BITS : width of one memory phrase
package blit_pkg;

  localparam int PHRASE_BITS = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;
  localparam logic [1:0] ST_WIN   = 2'd3;

endpackage

// File: rtl/srcdata_sequencer.sv
// Source phrase sequencer for the blitter source barrel shifter.
// Fetches source phrases over a req/ack port, keeps a two-phrase window
// (srcd1 = newest, srcd2 = previous), computes the source shift and offers
// one window per destination phrase to the write stage.
//
// Ports:
//   sys_clk, reset        clock, synchronous active-high reset
//   start, nphrase,       run configuration, latched on start in IDLE
//   srcenx, src_boff,
//   dst_boff, big_pix_in
//   src_req/src_ack/src_data   source fetch port
//   srcd1lo..srcd2hi, srcshift window and shift to the shifter
//   big_pix               registered pixel ordering
//   win_valid/win_ack     window handoff to the write stage
//   busy, done            run status
//   dbg_state             current sequencer state (for observation)
//
// Handshakes: a transfer happens on a cycle where the request/valid and the
// matching ack are both high. src_req stays high until acked; an ack with
// the request low is ignored. win_valid holds with a stable window until
// win_ack. src_req and win_valid are never high together, so the window
// cannot change while it is offered.
module srcdata_sequencer
  import blit_pkg::*;
#(
  parameter int NPHR_W = 10
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NPHR_W-1:0]      nphrase,
  input  logic                   srcenx,
  input  logic [5:0]             src_boff,
  input  logic [5:0]             dst_boff,
  input  logic                   big_pix_in,
  output logic                   src_req,
  input  logic                   src_ack,
  input  logic [PHRASE_BITS-1:0] src_data,
  output logic [31:0]            srcd1lo,
  output logic [31:0]            srcd1hi,
  output logic [31:0]            srcd2lo,
  output logic [31:0]            srcd2hi,
  output logic [5:0]             srcshift,
  output logic                   big_pix,
  output logic                   win_valid,
  input  logic                   win_ack,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  logic [1:0]             state_q, state_d;
  logic [NPHR_W-1:0]      remaining_q, remaining_d;
  logic [5:0]             shift_q, shift_d;
  logic                   big_pix_q, big_pix_d;
  logic                   done_q, done_d;
  logic [PHRASE_BITS-1:0] srcd1_q, srcd2_q;
  logic                   fetch_fire;

  assign src_req    = (state_q == ST_PRIME) || (state_q == ST_FETCH);
  assign win_valid  = (state_q == ST_WIN);
  assign busy       = (state_q != ST_IDLE);
  assign fetch_fire = src_req && src_ack;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    shift_d     = shift_q;
    big_pix_d   = big_pix_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // 6-bit wrap subtraction gives the mod-64 shift directly.
          shift_d     = src_boff - dst_boff;
          big_pix_d   = big_pix_in;
          remaining_d = nphrase;
          if (nphrase == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = srcenx ? ST_PRIME : ST_FETCH;
          end
        end
      end
      ST_PRIME: begin
        if (src_ack) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (src_ack) state_d = ST_WIN;
      end
      ST_WIN: begin
        if (win_ack) begin
          remaining_d = remaining_q - NPHR_W'(1);
          if (remaining_q == NPHR_W'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      shift_q     <= '0;
      big_pix_q   <= 1'b0;
      done_q      <= 1'b0;
      srcd1_q     <= '0;
      srcd2_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      shift_q     <= shift_d;
      big_pix_q   <= big_pix_d;
      done_q      <= done_d;
      if (fetch_fire) begin
        srcd2_q <= srcd1_q;
        srcd1_q <= src_data;
      end
    end
  end

  assign srcd1hi   = srcd1_q[63:32];
  assign srcd1lo   = srcd1_q[31:0];
  assign srcd2hi   = srcd2_q[63:32];
  assign srcd2lo   = srcd2_q[31:0];
  assign srcshift  = shift_q;
  assign big_pix   = big_pix_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_srcdata_sequencer.sv
module tb_srcdata_sequencer;

  localparam int NPHR_W = 10;

  logic              sys_clk = 1'b0;
  logic              reset;
  logic              start;
  logic [NPHR_W-1:0] nphrase;
  logic              srcenx;
  logic [5:0]        src_boff, dst_boff;
  logic              big_pix_in;
  logic              src_req, src_ack;
  logic [63:0]       src_data;
  logic [31:0]       srcd1lo, srcd1hi, srcd2lo, srcd2hi;
  logic [5:0]        srcshift;
  logic              big_pix, win_valid, win_ack, busy, done;
  logic [1:0]        dbg_state;

  srcdata_sequencer #(.NPHR_W(NPHR_W)) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start), .nphrase(nphrase),
    .srcenx(srcenx), .src_boff(src_boff), .dst_boff(dst_boff),
    .big_pix_in(big_pix_in), .src_req(src_req), .src_ack(src_ack),
    .src_data(src_data), .srcd1lo(srcd1lo), .srcd1hi(srcd1hi),
    .srcd2lo(srcd2lo), .srcd2hi(srcd2hi), .srcshift(srcshift),
    .big_pix(big_pix), .win_valid(win_valid), .win_ack(win_ack),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // scoreboard: expected windows as {srcd1, srcd2}
  logic [127:0] exp_q[$];
  logic [63:0]  m_d1, m_d2;
  logic [5:0]   exp_shift;
  logic         exp_big;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] window_now();
    return {srcd1hi, srcd1lo, srcd2hi, srcd2lo};
  endfunction

  task automatic do_start(input int n, input bit enx, input logic [5:0] sb,
                          input logic [5:0] db, input bit bp);
    nphrase    = NPHR_W'(n);
    srcenx     = enx;
    src_boff   = sb;
    dst_boff   = db;
    big_pix_in = bp;
    exp_shift  = sb - db;
    exp_big    = bp;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    chk("start_to_req", src_req, (n != 0));
  endtask

  // Serve one fetch after 'waits' idle cycles with the request pending.
  task automatic serve(input logic [63:0] d, input int waits, input bit makes_window);
    int n = 0;
    while (!src_req && n < 100) begin tick(); n++; end
    chk("src_req_wait", src_req, 1);
    chk("req_valid_excl", win_valid, 0);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("req_held", src_req, 1);
    end
    src_ack  = 1'b1;
    src_data = d;
    tick();
    src_ack  = 1'b0;
    src_data = {$urandom, $urandom};
    m_d2 = m_d1;
    m_d1 = d;
    if (makes_window) exp_q.push_back({m_d1, m_d2});
  endtask

  // Consume one window after holding win_ack low for 'hold' cycles.
  task automatic consume(input int hold, input bit last);
    int n = 0;
    logic [127:0] w, e;
    while (!win_valid && n < 100) begin tick(); n++; end
    chk("win_valid_wait", win_valid, 1);
    chk("valid_req_excl", src_req, 0);
    w = window_now();
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("window", w, e);
    end
    chk("srcshift", srcshift, exp_shift);
    chk("big_pix", big_pix, exp_big);
    for (int i = 0; i < hold; i++) begin
      src_ack  = (i % 3 == 1);
      src_data = {$urandom, $urandom};
      tick();
      chk("hold_valid", win_valid, 1);
      chk("hold_req", src_req, 0);
      chk("hold_window", window_now(), w);
      chk("hold_shift", srcshift, exp_shift);
    end
    src_ack = 1'b0;
    win_ack = 1'b1;
    tick();
    win_ack = 1'b0;
    chk("done", done, last);
    chk("busy", busy, !last);
    if (last) begin
      tick();
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; nphrase = '0; srcenx = 1'b0;
    src_boff = '0; dst_boff = '0; big_pix_in = 1'b0;
    src_ack = 1'b0; src_data = '0; win_ack = 1'b0;
    m_d1 = '0; m_d2 = '0; exp_shift = '0; exp_big = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_outs", {src_req, win_valid, busy, done, big_pix, srcshift}, 0);
    chk("rst_window", window_now(), 0);

    // Basic run: two windows, fetch acked after one wait cycle each.
    do_start(2, 1'b0, 6'd8, 6'd0, 1'b1);
    chk("basic_shift", srcshift, 6'd8);
    serve(64'hA0A1_A2A3_A4A5_A6A7, 1, 1'b1);
    consume(0, 1'b0);
    chk("win_ack_to_req", src_req, 1);
    serve(64'hB0B1_B2B3_B4B5_B6B7, 1, 1'b1);
    consume(0, 1'b1);

    // Priming fetch: two fetches before the only window.
    do_start(1, 1'b1, 6'd5, 6'd9, 1'b0);
    serve(64'h1111_2222_3333_4444, 0, 1'b0);
    chk("prime_no_valid", win_valid, 0);
    chk("prime_then_fetch", dbg_state, 2'd2);
    serve(64'h5555_6666_7777_8888, 2, 1'b1);
    consume(0, 1'b1);

    // Shift wrap cases, plus backpressure with stray acks during WIN.
    do_start(1, 1'b0, 6'd0, 6'd3, 1'b0);
    chk("shift_wrap_61", srcshift, 6'd61);
    serve({$urandom, $urandom}, 0, 1'b1);
    consume(10, 1'b1);
    do_start(1, 1'b0, 6'd63, 6'd63, 1'b1);
    chk("shift_zero", srcshift, 6'd0);
    serve({$urandom, $urandom}, 3, 1'b1);
    consume(4, 1'b1);

    // nphrase = 0: done next cycle, no fetch.
    do_start(0, 1'b0, 6'd1, 6'd2, 1'b0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_req", src_req, 0);
    tick();
    chk("zero_done_clear", done, 0);
    chk("zero_still_idle", src_req, 0);

    // start while busy is ignored.
    do_start(2, 1'b0, 6'd20, 6'd4, 1'b1);
    nphrase = NPHR_W'(7); src_boff = 6'd1; dst_boff = 6'd40; big_pix_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_shift", srcshift, exp_shift);
    chk("busy_start_bigpix", big_pix, exp_big);
    chk("busy_start_state", dbg_state, 2'd2);
    serve({$urandom, $urandom}, 0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    consume(1, 1'b0);
    serve({$urandom, $urandom}, 1, 1'b1);
    consume(0, 1'b1);

    // Reset while in FETCH, with an ack in the reset cycle.
    do_start(3, 1'b0, 6'd7, 6'd1, 1'b1);
    chk("pre_reset_fetch", dbg_state, 2'd2);
    reset = 1'b1; src_ack = 1'b1; src_data = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    reset = 1'b0; src_ack = 1'b0;
    m_d1 = '0; m_d2 = '0; exp_q.delete();
    chk("mid_reset_state", dbg_state, 2'd0);
    chk("mid_reset_outs", {src_req, win_valid, busy, done, big_pix, srcshift}, 0);
    chk("mid_reset_window", window_now(), 0);

    // Counter wrap: all-ones phrase count, acks in the request cycle.
    do_start((1 << NPHR_W) - 1, 1'b0, 6'd2, 6'd1, 1'b0);
    for (int i = 0; i < (1 << NPHR_W) - 1; i++) begin
      serve({$urandom, $urandom}, 0, 1'b1);
      consume(0, (i == (1 << NPHR_W) - 2));
    end
    chk("wrap_idle", dbg_state, 2'd0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
